// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported memory between instruction fetch and the data stage.
//           Data has fixed priority, and a streak limit forces a waiting fetch through.
// Latency : a request seen in IDLE raises mem_req the next cycle. The ready pulse comes one
//           cycle after mem_ready, so the minimum is 2 cycles and the best rate is 1 access per 3 cycles.
// Backpr. : each requester holds req until its one-cycle ready pulse. mem_req is held until
//           mem_ready. if_stall tells the pipeline that the fetch has not completed yet.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req/if_addr                 fetch request in; if_ready/if_rdata completion out; if_stall
//   d_req/d_we/d_addr/d_wdata      data request in; d_ready/d_rdata completion out
//   mem_req/mem_we/mem_addr/mem_wdata  memory request out; mem_ready/mem_rdata in
//   busy                           a transaction is in flight (state is not IDLE)
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        streak_q, streak_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d;
    logic              if_ready_d, d_ready_d, busy_d;
    logic              fetch_forced;

    // A pending fetch that has already waited out MAX_STREAK data grants wins the next slot.
    assign fetch_forced = if_req && (streak_q == STREAK_MAX);

    // Fetch stalls until its own response cycle.
    assign if_stall = if_req && !((state_q == S_RESP) && (owner_q == OWN_FETCH));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req && !fetch_forced) begin
                    state_d     = S_BUSY;
                    owner_d     = OWN_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // The streak only counts data grants that overtook a waiting fetch.
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (if_req) begin
                    state_d    = S_BUSY;
                    owner_d    = OWN_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    streak_d   = 4'd0;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    if (!mem_we) begin
                        if (owner_q == OWN_FETCH) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    if_ready_d = (owner_q == OWN_FETCH);
                    d_ready_d  = (owner_q == OWN_DATA);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_DATA;
            streak_q  <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter using directed requester and memory behaviour.
// Latency : a transaction-level model is checked against the DUT on every clock.
// Backpr. : the requesters hold req until ready, and the memory answers after a programmable number of mem_req cycles.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MS = 3;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dop_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester queues and memory knobs, changed by the stimulus thread at posedge+3.
    logic [AW-1:0] if_q[$];
    dop_t          d_q[$];
    int            mem_lat = 1;
    logic          stray_ready = 1'b0;
    logic          rd_fixed_en = 1'b0;
    logic [DW-1:0] rd_fixed = '0;

    // Requesters and memory responder, all driven on the falling edge.
    initial begin
        int   req_cycles;
        logic [AW-1:0] ftmp;
        dop_t dtmp;
        req_cycles = 0;
        forever begin
            @(negedge clk);
            if (if_req && if_ready && if_q.size() > 0) ftmp = if_q.pop_front();
            if (if_q.size() > 0) begin
                if_req  = 1'b1;
                if_addr = if_q[0];
            end else begin
                if_req = 1'b0;
            end
            if (d_req && d_ready && d_q.size() > 0) dtmp = d_q.pop_front();
            if (d_q.size() > 0) begin
                d_req   = 1'b1;
                d_we    = d_q[0].we;
                d_addr  = d_q[0].addr;
                d_wdata = d_q[0].wdata;
            end else begin
                d_req = 1'b0;
            end
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_fixed_en ? rd_fixed : (mem_addr ^ 16'h5A00);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 16'hFFFF;
                end
            end else begin
                req_cycles = 0;
                mem_ready  = stray_ready;
                mem_rdata  = 16'hDEAD;
            end
        end
    end

    // Transaction-level model: one access in flight, with a response phase after mem_ready.
    logic          m_active = 1'b0, m_resp = 1'b0, m_fetch = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
    logic          m_if_ready = 1'b0, m_d_ready = 1'b0;
    int            m_streak = 0;
    logic [AW-1:0] m_grants[$];
    logic [AW-1:0] dut_grants[$];
    int            if_ready_cnt = 0, d_ready_cnt = 0;
    logic          prev_mem_req = 1'b0;

    initial begin
        logic exp_stall;
        forever begin
            @(posedge clk);
            m_if_ready = 1'b0;
            m_d_ready  = 1'b0;
            if (rst) begin
                m_active = 1'b0; m_resp = 1'b0; m_streak = 0;
                m_we = 1'b0; m_addr = '0; m_wdata = '0;
                m_if_rdata = '0; m_d_rdata = '0;
            end else if (!m_active) begin
                if (d_req && !(if_req && m_streak == MS)) begin
                    m_active = 1'b1; m_fetch = 1'b0;
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                    m_streak = if_req ? ((m_streak < MS) ? m_streak + 1 : MS) : 0;
                    m_grants.push_back(d_addr);
                end else if (if_req) begin
                    m_active = 1'b1; m_fetch = 1'b1;
                    m_we = 1'b0; m_addr = if_addr;
                    m_streak = 0;
                    m_grants.push_back(if_addr);
                end
            end else if (!m_resp) begin
                if (mem_ready) begin
                    m_resp = 1'b1;
                    if (!m_we) begin
                        if (m_fetch) m_if_rdata = mem_rdata;
                        else         m_d_rdata  = mem_rdata;
                    end
                    if (m_fetch) m_if_ready = 1'b1;
                    else         m_d_ready  = 1'b1;
                end
            end else begin
                m_active = 1'b0;
                m_resp   = 1'b0;
            end
            #1;
            exp_stall = if_req && !(m_resp && m_fetch);
            chk("mem_req",   32'(mem_req),   32'(m_active && !m_resp));
            chk("mem_we",    32'(mem_we),    32'(m_we));
            chk("mem_addr",  32'(mem_addr),  32'(m_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            chk("if_ready",  32'(if_ready),  32'(m_if_ready));
            chk("d_ready",   32'(d_ready),   32'(m_d_ready));
            chk("if_rdata",  32'(if_rdata),  32'(m_if_rdata));
            chk("d_rdata",   32'(d_rdata),   32'(m_d_rdata));
            chk("busy",      32'(busy),      32'(m_active));
            chk("if_stall",  32'(if_stall),  32'(exp_stall));
            if (mem_req && !prev_mem_req) dut_grants.push_back(mem_addr);
            prev_mem_req = mem_req;
            if (if_ready) if_ready_cnt++;
            if (d_ready)  d_ready_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (if_q.size() == 0 && d_q.size() == 0 && !busy && !if_req && !d_req) done = 1'b1;
            #2;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        int ic, dc, nreq, nrdy;
        logic [AW-1:0] exp3[5];
        logic seen;

        // Reset state
        repeat (2) cyc();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // Single fetch, zero-wait memory returning 0x1234
        rst = 1'b0;
        rd_fixed_en = 1'b1; rd_fixed = 16'h1234; mem_lat = 1;
        if_q.push_back(16'h0040);
        @(posedge clk); #1;
        chk("t1_mem_req_c1", 32'(mem_req), 32'd1);
        chk("t1_mem_addr_c1", 32'(mem_addr), 32'h0040);
        chk("t1_mem_we_c1", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk("t1_if_ready_c2", 32'(if_ready), 32'd1);
        chk("t1_if_rdata_c2", 32'(if_rdata), 32'h1234);
        chk("t1_d_ready_c2", 32'(d_ready), 32'd0);
        #2;
        wait_idle("t1_timeout", 20);
        rd_fixed_en = 1'b0;

        // Data has priority over a simultaneous fetch
        dut_grants.delete();
        d_q.push_back('{we: 1'b0, addr: 16'h0100, wdata: 16'h0000});
        if_q.push_back(16'h0040);
        wait_idle("t2_timeout", 40);
        chk("t2_ngrants", 32'(dut_grants.size()), 32'd2);
        if (dut_grants.size() == 2) begin
            chk("t2_grant0", 32'(dut_grants[0]), 32'h0100);
            chk("t2_grant1", 32'(dut_grants[1]), 32'h0040);
        end

        // Starvation guard: expect D, D, D, F, D
        dut_grants.delete();
        m_grants.delete();
        exp3[0] = 16'h0300; exp3[1] = 16'h0302; exp3[2] = 16'h0304;
        exp3[3] = 16'h0044; exp3[4] = 16'h0306;
        for (int i = 0; i < 4; i++) d_q.push_back('{we: 1'b0, addr: 16'(16'h0300 + 2 * i), wdata: 16'h0000});
        if_q.push_back(16'h0044);
        wait_idle("t3_timeout", 80);
        chk("t3_ngrants_dut", 32'(dut_grants.size()), 32'd5);
        chk("t3_ngrants_model", 32'(m_grants.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_grants.size()) chk($sformatf("t3_dut_grant%0d", i), 32'(dut_grants[i]), 32'(exp3[i]));
            if (i < m_grants.size())   chk($sformatf("t3_model_grant%0d", i), 32'(m_grants[i]), 32'(exp3[i]));
        end
        chk("t3_d_rdata", 32'(d_rdata), 32'h5906);
        chk("t3_if_rdata", 32'(if_rdata), 32'h5A44);

        // Write with a 4-cycle memory wait
        mem_lat = 4;
        nreq = 0; nrdy = 0;
        d_q.push_back('{we: 1'b1, addr: 16'h0200, wdata: 16'hBEEF});
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                nreq++;
                chk("t4_fields", {15'd0, mem_we, mem_addr}, 32'h0001_0200);
                chk("t4_wdata", 32'(mem_wdata), 32'h0000_BEEF);
            end
            if (d_ready) nrdy++;
            #2;
        end
        chk("t4_mem_req_cycles", 32'(nreq), 32'd4);
        chk("t4_d_ready_pulses", 32'(nrdy), 32'd1);
        chk("t4_d_rdata_kept", 32'(d_rdata), 32'h5906);

        // Reset in the middle of an access, then a late mem_ready
        mem_lat = 100;
        d_q.push_back('{we: 1'b0, addr: 16'h0400, wdata: 16'h0000});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_req) seen = 1'b1;
            #2;
        end
        chk("t5_reached_busy", 32'(seen), 32'd1);
        ic = if_ready_cnt; dc = d_ready_cnt;
        rst = 1'b1;
        d_q.delete();
        cyc();
        chk("t5_mem_req_after_rst", 32'(mem_req), 32'd0);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();
        stray_ready = 1'b1;
        repeat (3) cyc();
        stray_ready = 1'b0;
        cyc();
        chk("t5_no_if_ready", 32'(if_ready_cnt - ic), 32'd0);
        chk("t5_no_d_ready", 32'(d_ready_cnt - dc), 32'd0);
        chk("t5_busy_end", 32'(busy), 32'd0);

        // Stray mem_ready while idle
        mem_lat = 2;
        if_q.push_back(16'h0048);
        wait_idle("t6_timeout", 20);
        chk("t6_if_rdata_pre", 32'(if_rdata), 32'h5A48);
        ic = if_ready_cnt; dc = d_ready_cnt;
        stray_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_idle_busy", 32'(busy), 32'd0);
            chk("t6_idle_mem_req", 32'(mem_req), 32'd0);
            #2;
        end
        stray_ready = 1'b0;
        cyc();
        chk("t6_if_rdata_kept", 32'(if_rdata), 32'h5A48);
        chk("t6_d_rdata_kept", 32'(d_rdata), 32'h0000);
        chk("t6_no_ready", 32'((if_ready_cnt - ic) + (d_ready_cnt - dc)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
